// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared opcodes, funct3 codes, ALU/FSM enums and immediate generator for the RV32I core
package rv_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
   } alu_op_t;

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
   } state_t;

   function automatic logic [31:0] imm_gen(input logic [31:0] ir);
      logic [31:0] imm;
      case (ir[6:0])
         OPC_STORE:         imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         OPC_BRANCH:        imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC: imm = {ir[31:12], 12'h000};
         OPC_JAL:           imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default:           imm = {{20{ir[31]}}, ir[31:20]};
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/rv_alu.sv
// rtl/rv_alu.sv - combinational RV32I ALU with branch-compare flags
module rv_alu
   import rv_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_op_t     alu_op,
   output logic [31:0] result,
   output logic        eq,
   output logic        lt,
   output logic        ltu
);

   assign eq  = (a == b);
   assign lt  = ($signed(a) < $signed(b));
   assign ltu = (a < b);

   always_comb begin
      result = '0;
      case (alu_op)
         ALU_ADD:    result = a + b;
         ALU_SUB:    result = a - b;
         ALU_SLL:    result = a << b[4:0];
         ALU_SLT:    result = {31'd0, lt};
         ALU_SLTU:   result = {31'd0, ltu};
         ALU_XOR:    result = a ^ b;
         ALU_SRL:    result = a >> b[4:0];
         ALU_SRA:    result = $unsigned($signed(a) >>> b[4:0]);
         ALU_OR:     result = a | b;
         ALU_AND:    result = a & b;
         ALU_PASS_B: result = b;
         default:    result = '0;
      endcase
   end

endmodule

// File: rtl/risc_v_core.sv
// rtl/risc_v_core.sv - 5-cycle multi-cycle RV32I core with imem/dmem/regfile and MMIO port; PERF_COUNTERS_EN adds cycle/instret counters
module risc_v_core
   import rv_pkg::*;
#(
   parameter int CORE         = 0,
   parameter int DATA_WIDTH   = 32,
   parameter int INDEX_BITS   = 6,
   parameter int OFFSET_BITS  = 3,
   parameter int ADDRESS_BITS = 12
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDRESS_BITS-1:0] prog_address,
   input  logic                    isp_write,
   input  logic [ADDRESS_BITS-1:0] isp_address,
   input  logic [DATA_WIDTH-1:0]   isp_data,
   input  logic [1:0]              from_peripheral,
   input  logic [31:0]             from_peripheral_data,
   input  logic                    from_peripheral_valid,
   output logic [1:0]              to_peripheral,
   output logic [31:0]             to_peripheral_data,
   output logic                    to_peripheral_valid,
   input  logic                    report
);

   logic [DATA_WIDTH-1:0] imem [0:2**ADDRESS_BITS-1];
   logic [31:0]           regs [0:31];
   logic [31:0]           dmem [0:2**ADDRESS_BITS-1];

   state_t      state, state_next;
   logic [31:0] pc, ir, rs1_v, rs2_v, imm, alu_res, target, ld_data;
   logic        take, req_sent;

   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic        f7b;
   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign f3     = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign f7b    = ir[30];

   alu_op_t     alu_op;
   logic [31:0] alu_a, alu_b, alu_y;
   logic        alu_eq, alu_lt, alu_ltu;

   always_comb begin
      alu_op = ALU_ADD;
      if (opcode == OPC_LUI) begin
         alu_op = ALU_PASS_B;
      end else if (opcode == OPC_OP || opcode == OPC_IMM) begin
         case (f3)
            F3_ADD:  alu_op = (opcode == OPC_OP && f7b) ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_op = ALU_SLL;
            F3_SLT:  alu_op = ALU_SLT;
            F3_SLTU: alu_op = ALU_SLTU;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SR:   alu_op = f7b ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            default: alu_op = ALU_AND;
         endcase
      end
   end

   assign alu_a = (opcode == OPC_AUIPC) ? pc : rs1_v;
   assign alu_b = (opcode == OPC_OP || opcode == OPC_BRANCH) ? rs2_v : imm;

   rv_alu u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .alu_op (alu_op),
      .result (alu_y),
      .eq     (alu_eq),
      .lt     (alu_lt),
      .ltu    (alu_ltu)
   );

   logic branch_take;
   always_comb begin
      branch_take = 1'b0;
      case (f3)
         F3_BEQ:  branch_take = alu_eq;
         F3_BNE:  branch_take = !alu_eq;
         F3_BLT:  branch_take = alu_lt;
         F3_BGE:  branch_take = !alu_lt;
         F3_BLTU: branch_take = alu_ltu;
         F3_BGEU: branch_take = !alu_ltu;
         default: branch_take = 1'b0;
      endcase
   end

   // Memory-stage address decode: bit 31 selects MMIO, otherwise a word index into dmem
   logic                    is_mmio, is_load, is_store, mmio_resp;
   logic [ADDRESS_BITS-1:0] dmem_idx;
   logic [31:0]             ld_word, ld_ext, st_data;
   logic [7:0]              ld_byte;
   logic [15:0]             ld_half;
   logic [3:0]              st_be;
   assign is_mmio   = alu_res[31];
   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign mmio_resp = from_peripheral_valid && (from_peripheral == 2'b10);
   assign dmem_idx  = alu_res[ADDRESS_BITS+1:2];
   assign ld_word   = dmem[dmem_idx];
   assign ld_byte   = ld_word[{alu_res[1:0], 3'b000} +: 8];
   assign ld_half   = ld_word[{alu_res[1], 4'b0000} +: 16];

   always_comb begin
      case (f3)
         F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
         F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
         F3_BU:   ld_ext = {24'd0, ld_byte};
         F3_HU:   ld_ext = {16'd0, ld_half};
         default: ld_ext = ld_word;
      endcase
   end

   always_comb begin
      st_be   = 4'b1111;
      st_data = rs2_v;
      case (f3)
         F3_B: begin
            st_be   = 4'b0001 << alu_res[1:0];
            st_data = {4{rs2_v[7:0]}};
         end
         F3_H: begin
            st_be   = alu_res[1] ? 4'b1100 : 4'b0011;
            st_data = {2{rs2_v[15:0]}};
         end
         default: st_be = 4'b1111;
      endcase
   end

   logic        writes_rd, is_halt;
   logic [31:0] wb_value;
   assign writes_rd = (opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL) ||
                      (opcode == OPC_JALR) || (opcode == OPC_LOAD) || (opcode == OPC_IMM) ||
                      (opcode == OPC_OP);
   assign is_halt   = (opcode == OPC_SYSTEM) && (f3 == 3'b000);
   assign wb_value  = (opcode == OPC_JAL || opcode == OPC_JALR) ? pc + 32'd4 :
                      is_load ? ld_data : alu_res;

   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, HALT: if (start) state_next = FETCH;
         FETCH:      state_next = DECODE;
         DECODE:     state_next = EXEC;
         EXEC:       state_next = MEM;
         MEM:        if (!(is_load && is_mmio) || mmio_resp) state_next = WB;
         WB:         state_next = is_halt ? HALT : FETCH;
         default:    state_next = IDLE;
      endcase
   end

   always_comb begin
      to_peripheral       = 2'b00;
      to_peripheral_data  = '0;
      to_peripheral_valid = 1'b0;
      if (state == MEM && is_mmio && !req_sent) begin
         if (is_store) begin
            to_peripheral       = 2'b01;
            to_peripheral_data  = rs2_v;
            to_peripheral_valid = 1'b1;
         end else if (is_load) begin
            to_peripheral       = 2'b10;
            to_peripheral_data  = alu_res;
            to_peripheral_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         pc       <= '0;
         req_sent <= 1'b0;
      end else begin
         req_sent <= (state == MEM);
         case (state)
            IDLE, HALT: if (start) pc <= {{(30-ADDRESS_BITS){1'b0}}, prog_address, 2'b00};
            FETCH:      ir <= imem[pc[ADDRESS_BITS+1:2]];
            DECODE: begin
               rs1_v <= (rs1 == 5'd0) ? '0 : regs[rs1];
               rs2_v <= (rs2 == 5'd0) ? '0 : regs[rs2];
               imm   <= imm_gen(ir);
            end
            EXEC: begin
               alu_res <= alu_y;
               take    <= (opcode == OPC_JAL) || (opcode == OPC_JALR) ||
                          (opcode == OPC_BRANCH && branch_take);
               target  <= (opcode == OPC_JALR) ? (alu_y & ~32'd1) : pc + imm;
            end
            MEM:        if (is_load) ld_data <= is_mmio ? from_peripheral_data : ld_ext;
            WB:         pc <= (take ? target : pc + 32'd4) & ~32'd3;
            default:    ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset && state == WB && writes_rd && rd != 5'd0) regs[rd] <= wb_value;
   end

   always_ff @(posedge clock) begin
      if (reset && state == MEM && is_store && !is_mmio) begin
         for (int i = 0; i < 4; i++) begin
            if (st_be[i]) dmem[dmem_idx][8*i +: 8] <= st_data[8*i +: 8];
         end
      end
   end

   // ISP writes land regardless of FSM state or reset
   always_ff @(posedge clock) begin
      if (isp_write) imem[isp_address] <= isp_data;
   end

`ifdef PERF_COUNTERS_EN
   logic [31:0] cycle_count, instret_count;
   always_ff @(posedge clock) begin
      if (!reset) begin
         cycle_count   <= '0;
         instret_count <= '0;
      end else begin
         if (state != IDLE && state != HALT) cycle_count <= cycle_count + 32'd1;
         if (state == WB) instret_count <= instret_count + 32'd1;
         if (report) $display("Core %0d: cycles=%0d instret=%0d", CORE, cycle_count, instret_count);
      end
   end
   logic [31:0] unused_cfg;
   assign unused_cfg = INDEX_BITS ^ OFFSET_BITS;
`else
   logic [31:0] unused_cfg;
   assign unused_cfg = CORE ^ INDEX_BITS ^ OFFSET_BITS ^ {31'd0, report};
`endif

endmodule

// File: tb/tb_risc_v_core.sv
// tb/tb_risc_v_core.sv - directed self-checking bench for risc_v_core
module tb_risc_v_core;
   import rv_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [11:0] prog_address = '0;
   logic        isp_write = 1'b0;
   logic [11:0] isp_address = '0;
   logic [31:0] isp_data = '0;
   logic [1:0]  from_peripheral = 2'b00;
   logic [31:0] from_peripheral_data = '0;
   logic        from_peripheral_valid = 1'b0;
   logic [1:0]  to_peripheral;
   logic [31:0] to_peripheral_data;
   logic        to_peripheral_valid;
   logic        report = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   risc_v_core #(.CORE(0), .DATA_WIDTH(32), .INDEX_BITS(6), .OFFSET_BITS(3), .ADDRESS_BITS(12)) dut (
      .clock                 (clock),
      .reset                 (reset),
      .start                 (start),
      .prog_address          (prog_address),
      .isp_write             (isp_write),
      .isp_address           (isp_address),
      .isp_data              (isp_data),
      .from_peripheral       (from_peripheral),
      .from_peripheral_data  (from_peripheral_data),
      .from_peripheral_valid (from_peripheral_valid),
      .to_peripheral         (to_peripheral),
      .to_peripheral_data    (to_peripheral_data),
      .to_peripheral_valid   (to_peripheral_valid),
      .report                (report)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic clear_regs;
      for (int i = 0; i < 32; i++) dut.regs[i] = 32'd0;
   endtask

   task automatic pulse_start(input logic [11:0] addr);
      prog_address = addr;
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_halt(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (dut.state == HALT) begin
            ok = 1'b1;
            break;
         end
         step(1);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      step(2);
      n_tests++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
      n_tests++; if (dut.pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", dut.pc); end
      n_tests++; if (to_peripheral !== 2'b00 || to_peripheral_valid !== 1'b0 || to_peripheral_data !== 32'd0) begin
         n_fail++; $display("FAIL reset_outputs: got %b/%h/%b want 00/0/0", to_peripheral, to_peripheral_data, to_peripheral_valid);
      end
      reset = 1'b1;
      step(1);
   endtask

   task automatic test_addi_ecall;
      logic [31:0] prog [0:2];
      prog = '{32'h00500093, 32'h00700013, 32'h00000073};
      for (int i = 0; i < 3; i++) begin
         isp_address = 12'(i);
         isp_data = prog[i];
         isp_write = 1'b1;
         step(1);
      end
      isp_write = 1'b0;
      clear_regs();
      pulse_start(12'd0);
      step(19);
      n_tests++; if (dut.regs[1] !== 32'd5) begin n_fail++; $display("FAIL addi_x1: got %h want 5", dut.regs[1]); end
      n_tests++; if (dut.regs[0] !== 32'd0) begin n_fail++; $display("FAIL addi_x0: got %h want 0", dut.regs[0]); end
      n_tests++; if (dut.state !== HALT) begin n_fail++; $display("FAIL addi_halt: got %0d want %0d", dut.state, HALT); end
      n_tests++; if (dut.pc !== 32'h0000000C) begin n_fail++; $display("FAIL addi_pc: got %h want c", dut.pc); end
   endtask

   task automatic test_binary_search;
      logic [31:0] prog [0:17];
      bit ok;
      prog = '{32'h00000293, 32'h00700313, 32'h00B00393, 32'h02534A63,
               32'h00628533, 32'h00155513, 32'h00251593, 32'h0005A603,
               32'h00760C63, 32'h00764663, 32'hFFF50313, 32'hFE1FF06F,
               32'h00150293, 32'hFD9FF06F, 32'h00050493, 32'h00000073,
               32'hFFF00493, 32'h00000073};
      for (int i = 0; i < 18; i++) dut.imem[i] = prog[i];
      for (int i = 0; i < 8; i++) dut.dmem[i] = 32'(2*i + 1);
      clear_regs();
      pulse_start(12'd0);
      wait_halt(5000, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL bsearch_halt: got no halt want halt within 5000 cycles"); end
      n_tests++; if (dut.regs[9] !== 32'h00000005) begin n_fail++; $display("FAIL bsearch_x9: got %h want 00000005", dut.regs[9]); end
      n_tests++; if (dut.regs[5] !== 32'd4) begin n_fail++; $display("FAIL bsearch_lo: got %h want 4", dut.regs[5]); end
   endtask

   task automatic test_load_store;
      logic [31:0] prog [0:6];
      bit ok;
      prog = '{32'h00202823, 32'h01000183, 32'h01004203, 32'h002009A3,
               32'h01002283, 32'h01201303, 32'h00000073};
      for (int i = 0; i < 7; i++) dut.imem[12'h040 + i] = prog[i];
      dut.dmem[4] = 32'hFFFFFFFF;
      clear_regs();
      dut.regs[2] = 32'h000000F0;
      pulse_start(12'h040);
      wait_halt(200, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL ls_halt: got no halt want halt within 200 cycles"); end
      n_tests++; if (dut.regs[3] !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL ls_lb: got %h want fffffff0", dut.regs[3]); end
      n_tests++; if (dut.regs[4] !== 32'h000000F0) begin n_fail++; $display("FAIL ls_lbu: got %h want 000000f0", dut.regs[4]); end
      n_tests++; if (dut.regs[5] !== 32'hF00000F0) begin n_fail++; $display("FAIL ls_sb_lw: got %h want f00000f0", dut.regs[5]); end
      n_tests++; if (dut.regs[6] !== 32'hFFFFF000) begin n_fail++; $display("FAIL ls_lh: got %h want fffff000", dut.regs[6]); end
      n_tests++; if (dut.pc !== 32'h0000011C) begin n_fail++; $display("FAIL ls_pc: got %h want 0000011c", dut.pc); end
   endtask

   task automatic test_mmio;
      logic [31:0] prog [0:4];
      bit found;
      bit ok;
      prog = '{32'h800000B7, 32'h0A500113, 32'h0020A023, 32'h0000A183, 32'h00000073};
      for (int i = 0; i < 5; i++) dut.imem[12'h080 + i] = prog[i];
      clear_regs();
      pulse_start(12'h080);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (to_peripheral_valid) begin found = 1'b1; break; end
         step(1);
      end
      n_tests++; if (!found) begin n_fail++; $display("FAIL mmio_store_req: got no request want one within 100 cycles"); end
      n_tests++; if (to_peripheral !== 2'b01 || to_peripheral_data !== 32'h000000A5) begin
         n_fail++; $display("FAIL mmio_store_fields: got %b/%h want 01/000000a5", to_peripheral, to_peripheral_data);
      end
      step(1);
      n_tests++; if (to_peripheral_valid !== 1'b0) begin n_fail++; $display("FAIL mmio_store_oneshot: got valid %b want 0", to_peripheral_valid); end
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (to_peripheral_valid) begin found = 1'b1; break; end
         step(1);
      end
      n_tests++; if (!found || to_peripheral !== 2'b10 || to_peripheral_data !== 32'h80000000) begin
         n_fail++; $display("FAIL mmio_load_req: got %b/%b/%h want 1/10/80000000", found, to_peripheral, to_peripheral_data);
      end
      step(3);
      from_peripheral = 2'b01;
      from_peripheral_valid = 1'b1;
      from_peripheral_data = 32'hBAD0BAD0;
      step(1);
      from_peripheral_valid = 1'b0;
      step(1);
      n_tests++; if (dut.state !== MEM || to_peripheral_valid !== 1'b0) begin
         n_fail++; $display("FAIL mmio_stall: got state %0d valid %b want %0d/0", dut.state, to_peripheral_valid, MEM);
      end
      from_peripheral = 2'b10;
      from_peripheral_data = 32'h00001234;
      from_peripheral_valid = 1'b1;
      step(1);
      from_peripheral_valid = 1'b0;
      from_peripheral = 2'b00;
      wait_halt(50, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL mmio_halt: got no halt want halt within 50 cycles"); end
      n_tests++; if (dut.regs[3] !== 32'h00001234) begin n_fail++; $display("FAIL mmio_load_data: got %h want 00001234", dut.regs[3]); end
   endtask

   task automatic test_branch_jal;
      logic [31:0] fetched [$];
      logic [31:0] want [0:4];
      want = '{32'h00, 32'h04, 32'h08, 32'h20, 32'h28};
      for (int i = 0; i < 11; i++) dut.imem[i] = 32'h00000073;
      dut.imem[0] = 32'h00300293;
      dut.imem[1] = 32'h00028463;
      dut.imem[2] = 32'h00000C63;
      dut.imem[3] = 32'h00100313;
      dut.imem[8] = 32'h008000EF;
      dut.imem[9] = 32'h00100393;
      clear_regs();
      pulse_start(12'd0);
      for (int i = 0; i < 100; i++) begin
         if (dut.state == HALT) break;
         if (dut.state == FETCH) fetched.push_back(dut.pc);
         step(1);
      end
      n_tests++; if (fetched.size() != 5) begin n_fail++; $display("FAIL br_fetch_count: got %0d want 5", fetched.size()); end
      for (int i = 0; i < 5 && i < fetched.size(); i++) begin
         n_tests++; if (fetched[i] !== want[i]) begin n_fail++; $display("FAIL br_fetch_pc[%0d]: got %h want %h", i, fetched[i], want[i]); end
      end
      n_tests++; if (dut.regs[1] !== 32'h24) begin n_fail++; $display("FAIL jal_link: got %h want 00000024", dut.regs[1]); end
      n_tests++; if (dut.regs[6] !== 32'd0 || dut.regs[7] !== 32'd0) begin
         n_fail++; $display("FAIL br_skipped: got x6=%h x7=%h want 0/0", dut.regs[6], dut.regs[7]);
      end
   endtask

   task automatic test_reset_mid_exec;
      bit hit;
      bit ok;
      dut.imem[0] = 32'h00900413;
      dut.imem[1] = 32'h00000073;
      dut.regs[8] = 32'h00000077;
      pulse_start(12'd0);
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (dut.state == EXEC) begin hit = 1'b1; break; end
         step(1);
      end
      reset = 1'b0;
      step(1);
      n_tests++; if (!hit || dut.state !== IDLE) begin n_fail++; $display("FAIL rst_exec_state: got hit %b state %0d want 1/%0d", hit, dut.state, IDLE); end
      n_tests++; if (dut.pc !== 32'd0 || to_peripheral_valid !== 1'b0 || to_peripheral !== 2'b00) begin
         n_fail++; $display("FAIL rst_exec_outputs: got pc %h valid %b code %b want 0/0/00", dut.pc, to_peripheral_valid, to_peripheral);
      end
      reset = 1'b1;
      step(6);
      n_tests++; if (dut.regs[8] !== 32'h00000077 || dut.state !== IDLE) begin
         n_fail++; $display("FAIL rst_exec_nowrite: got x8 %h state %0d want 00000077/%0d", dut.regs[8], dut.state, IDLE);
      end
      pulse_start(12'd0);
      wait_halt(50, ok);
      n_tests++; if (!ok || dut.regs[8] !== 32'd9) begin n_fail++; $display("FAIL rst_exec_rerun: got halt %b x8 %h want 1/00000009", ok, dut.regs[8]); end
   endtask

   task automatic test_isp_running;
      dut.imem[0] = 32'h0000006F;
      dut.imem[3] = 32'h00000000;
      pulse_start(12'd0);
      step(7);
      isp_address = 12'd3;
      isp_data = 32'hDEADBEEF;
      isp_write = 1'b1;
      step(1);
      isp_write = 1'b0;
      n_tests++; if (dut.imem[3] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL isp_write: got %h want deadbeef", dut.imem[3]); end
      n_tests++; if (dut.state === IDLE || dut.state === HALT) begin n_fail++; $display("FAIL isp_running: got state %0d want running", dut.state); end
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      step(1);
   endtask

   initial begin
      test_reset();
      test_addi_ecall();
      test_binary_search();
      test_load_store();
      test_mmio();
      test_branch_jal();
      test_reset_mid_exec();
      test_isp_running();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
